// File: rtl/hist_eq_pkg.sv
// Shared types and sizes for the histogram-equalisation datapath.
// Combinational only: no latency.
// No flow control: constants, state encoding and a lane-scan helper.
package hist_eq_pkg;

   localparam int BIN_W  = 16;
   localparam int LANES  = 8;
   localparam int WORD_W = BIN_W * LANES;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   typedef struct packed {
      logic             found;
      logic [BIN_W-1:0] val;
   } min_pick_t;

   // Returns the value of the lowest-index nonzero lane of a word, if any.
   function automatic min_pick_t first_nonzero(input logic [WORD_W-1:0] w);
      min_pick_t r;
      r = '0;
      for (int i = LANES - 1; i >= 0; i--) begin
         if (w[i*BIN_W +: BIN_W] != '0) begin
            r.found = 1'b1;
            r.val   = w[i*BIN_W +: BIN_W];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/cdf_lane_prefix.sv
// 8-lane inclusive prefix adder seeded by a running carry; CDF_SATURATE_EN clamps at all-ones, else wraps.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result and carry-out are consumed.
module cdf_lane_prefix
   import hist_eq_pkg::*;
(
   input  logic [WORD_W-1:0] bins_i,
   input  logic [BIN_W-1:0]  carry_i,
   output logic [WORD_W-1:0] sums_o,
   output logic [BIN_W-1:0]  carry_o
);

   // Ripple the running sum through the lanes, lane 0 first.
   always_comb begin
      logic [BIN_W-1:0] run;
`ifdef CDF_SATURATE_EN
      logic [BIN_W:0]   acc;
`endif
      run    = carry_i;
      sums_o = '0;
      for (int i = 0; i < LANES; i++) begin
`ifdef CDF_SATURATE_EN
         acc = {1'b0, run} + {1'b0, bins_i[i*BIN_W +: BIN_W]};
         run = acc[BIN_W] ? {BIN_W{1'b1}} : acc[BIN_W-1:0];
`else
         run = run + bins_i[i*BIN_W +: BIN_W];
`endif
         sums_o[i*BIN_W +: BIN_W] = run;
      end
      carry_o = run;
   end

endmodule

// File: rtl/cdf_builder.sv
// Streams NUM_WORDS histogram words, writes their running-sum CDF words and latches the first nonzero CDF value.
// Latency: address k at cycle k+1, write k at cycle k+3, done at cycle NUM_WORDS+3 after the start edge.
// Backpressure: none; start is ignored while a pass is in flight. Optional macro: CDF_SATURATE_EN.
module cdf_builder
   import hist_eq_pkg::*;
#(
   parameter logic [15:0] HIST_BASE = 16'h0000,
   parameter logic [15:0] CDF_BASE  = 16'h0000,
   parameter int          NUM_WORDS = 32
)(
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   output logic [15:0]       Hist_ReadAddress,
   input  logic [WORD_W-1:0] Hist_ReadBus,
   output logic              WriteEnable,
   output logic [15:0]       Cdf_MEMAddress,
   output logic [WORD_W-1:0] Cdf_MEMBus,
   output logic [BIN_W-1:0]  CdfMin,
   output logic              done
);

   localparam logic [15:0] LAST_IDX = 16'(NUM_WORDS - 1);

   state_t            state_q;
   logic [15:0]       rd_cnt_q;
   logic [15:0]       wr_cnt_q;
   logic [15:0]       rd_addr_q;
   logic              addr_vld_q;   // an address is on the bus this cycle
   logic              data_vld_q;   // its data is on Hist_ReadBus this cycle
   logic              wr_vld_q;
   logic [15:0]       wr_addr_q;
   logic [WORD_W-1:0] wr_dat_q;
   logic [BIN_W-1:0]  carry_q;
   logic [BIN_W-1:0]  min_q;
   logic              min_found_q;
   logic              done_q;

   logic [WORD_W-1:0] lane_sum;
   logic [BIN_W-1:0]  carry_d;
   min_pick_t         pick;

   cdf_lane_prefix u_prefix (
      .bins_i  (Hist_ReadBus),
      .carry_i (carry_q),
      .sums_o  (lane_sum),
      .carry_o (carry_d)
   );

   assign pick = first_nonzero(lane_sum);

   // Sequencer, read-address issue, two-stage read pipeline and registered CDF write port.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         rd_cnt_q    <= '0;
         wr_cnt_q    <= '0;
         rd_addr_q   <= HIST_BASE;
         addr_vld_q  <= 1'b0;
         data_vld_q  <= 1'b0;
         wr_vld_q    <= 1'b0;
         wr_addr_q   <= CDF_BASE;
         wr_dat_q    <= '0;
         carry_q     <= '0;
         min_q       <= '0;
         min_found_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         addr_vld_q <= 1'b0;
         data_vld_q <= addr_vld_q;
         wr_vld_q   <= 1'b0;

         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_q     <= S_READ;
                  rd_cnt_q    <= '0;
                  wr_cnt_q    <= '0;
                  carry_q     <= '0;
                  min_q       <= '0;
                  min_found_q <= 1'b0;
                  done_q      <= 1'b0;
               end
            end
            S_READ: begin
               rd_addr_q  <= HIST_BASE + rd_cnt_q;
               addr_vld_q <= 1'b1;
               rd_cnt_q   <= rd_cnt_q + 16'd1;
               if (rd_cnt_q == LAST_IDX) begin
                  state_q <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               // Pipeline empty means the final word has already been written.
               if (!addr_vld_q && !data_vld_q) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase

         // Read data for an earlier address is present: emit its CDF word.
         if (data_vld_q) begin
            wr_vld_q  <= 1'b1;
            wr_addr_q <= CDF_BASE + wr_cnt_q;
            wr_dat_q  <= lane_sum;
            carry_q   <= carry_d;
            wr_cnt_q  <= wr_cnt_q + 16'd1;
            if (!min_found_q && pick.found) begin
               min_q       <= pick.val;
               min_found_q <= 1'b1;
            end
         end
      end
   end

   assign Hist_ReadAddress = rd_addr_q;
   assign WriteEnable      = wr_vld_q;
   assign Cdf_MEMAddress   = wr_addr_q;
   assign Cdf_MEMBus       = wr_dat_q;
   assign CdfMin           = min_q;
   assign done             = done_q;

endmodule

// File: tb/tb_cdf_builder.sv
// Self-checking bench: directed and random histograms against a bin-level running-sum model.
// Cycle 0 is the edge that samples start; outputs are sampled 1 time unit after each rising edge.
// Build with CDF_SATURATE_EN defined to check the clamping variant.
module tb_cdf_builder;

   localparam int          NW = 32;
   localparam logic [15:0] HB = 16'h0100;
   localparam logic [15:0] CB = 16'h2000;

   logic         clock;
   logic         reset;
   logic         start;
   logic [15:0]  Hist_ReadAddress;
   logic [127:0] Hist_ReadBus;
   logic         WriteEnable;
   logic [15:0]  Cdf_MEMAddress;
   logic [127:0] Cdf_MEMBus;
   logic [15:0]  CdfMin;
   logic         done;

   logic [15:0] hist    [256];
   logic [15:0] exp_cdf [256];
   logic [15:0] exp_min;

   int n_checks;
   int n_err;

   cdf_builder #(
      .HIST_BASE (HB),
      .CDF_BASE  (CB),
      .NUM_WORDS (NW)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .start            (start),
      .Hist_ReadAddress (Hist_ReadAddress),
      .Hist_ReadBus     (Hist_ReadBus),
      .WriteEnable      (WriteEnable),
      .Cdf_MEMAddress   (Cdf_MEMAddress),
      .Cdf_MEMBus       (Cdf_MEMBus),
      .CdfMin           (CdfMin),
      .done             (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Synchronous histogram memory: data for an address appears the cycle after it.
   always @(posedge clock) begin
      int idx;
      idx = int'(Hist_ReadAddress) - int'(HB);
      if (idx >= 0 && idx < NW) begin
         for (int i = 0; i < 8; i++) Hist_ReadBus[i*16 +: 16] <= hist[idx*8 + i];
      end else begin
         Hist_ReadBus <= {8{16'hDEAD}};
      end
   end

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference: CDF(b) is the plain sum of bins 0..b, clamped or wrapped at 16 bits.
   task automatic build_model();
      int s;
      s = 0;
      exp_min = 16'd0;
      for (int b = 0; b < 256; b++) begin
         s = s + int'(hist[b]);
`ifdef CDF_SATURATE_EN
         if (s > 65535) s = 65535;
`else
         s = s % 65536;
`endif
         exp_cdf[b] = 16'(s);
      end
      for (int b = 255; b >= 0; b--) begin
         if (exp_cdf[b] != 16'd0) exp_min = exp_cdf[b];
      end
   endtask

   function automatic logic [127:0] exp_word(input int k);
      logic [127:0] w;
      for (int i = 0; i < 8; i++) w[i*16 +: 16] = exp_cdf[k*8 + i];
      return w;
   endfunction

   task automatic check_reset_state(input string tag);
      chk({tag, "_we"},    WriteEnable,      1'b0);
      chk({tag, "_done"},  done,             1'b0);
      chk({tag, "_raddr"}, Hist_ReadAddress, HB);
      chk({tag, "_waddr"}, Cdf_MEMAddress,   CB);
      chk({tag, "_wbus"},  Cdf_MEMBus,       128'd0);
      chk({tag, "_min"},   CdfMin,           16'd0);
   endtask

   // One pass from IDLE or DONE; abort_at>0 applies reset at that cycle, pulse_mid pokes start at cycle 10.
   task automatic run_pass(input int abort_at, input bit pulse_mid);
      build_model();
      @(negedge clock);
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      chk("done_c0", done, 1'b0);
      chk("min_c0", CdfMin, 16'd0);
      for (int c = 1; c <= NW + 5; c++) begin
         @(posedge clock);
         #1;
         if (abort_at == c) begin
            reset = 1'b1;
            #1;
            check_reset_state("abort");
            repeat (3) begin
               @(posedge clock);
               #1;
               chk("we_in_reset", WriteEnable, 1'b0);
            end
            @(negedge clock);
            reset = 1'b0;
            return;
         end
         if (c <= NW) chk($sformatf("raddr_c%0d", c), Hist_ReadAddress, HB + 16'(c - 1));
         chk($sformatf("we_c%0d", c), WriteEnable, (c >= 3 && c <= NW + 2));
         if (WriteEnable && c >= 3 && c <= NW + 2) begin
            chk($sformatf("waddr_c%0d", c), Cdf_MEMAddress, CB + 16'(c - 3));
            chk($sformatf("wdat_k%0d", c - 3), Cdf_MEMBus, exp_word(c - 3));
         end
         chk($sformatf("done_c%0d", c), done, (c >= NW + 3));
         start = (pulse_mid && c == 9);
      end
      chk("cdfmin", CdfMin, exp_min);
      chk("hold_waddr", Cdf_MEMAddress, CB + 16'(NW - 1));
      chk("hold_wdat", Cdf_MEMBus, exp_word(NW - 1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      n_checks = 0;
      n_err    = 0;
      reset    = 1'b1;
      start    = 1'b0;
      for (int b = 0; b < 256; b++) hist[b] = 16'd0;
      repeat (2) @(posedge clock);
      #1;
      check_reset_state("reset");
      @(negedge clock);
      reset = 1'b0;

      // All bins one, with a stray start mid-pass, then a rerun from DONE.
      for (int b = 0; b < 256; b++) hist[b] = 16'd1;
      run_pass(0, 1'b1);
      chk("ones_min", CdfMin, 16'd1);
      run_pass(0, 1'b0);

      // Single spike at bin 200.
      for (int b = 0; b < 256; b++) hist[b] = 16'd0;
      hist[200] = 16'd500;
      run_pass(0, 1'b0);
      chk("spike_min", CdfMin, 16'd500);

      // Overflow at bin 63.
      for (int b = 0; b < 256; b++) hist[b] = 16'h0400;
      run_pass(0, 1'b0);

      // Empty histogram.
      for (int b = 0; b < 256; b++) hist[b] = 16'd0;
      run_pass(0, 1'b0);
      chk("zero_min", CdfMin, 16'd0);

      // Reset at cycle 10, then a clean pass.
      for (int b = 0; b < 256; b++) hist[b] = 16'($urandom_range(0, 50));
      run_pass(10, 1'b0);
      check_reset_state("post_abort");
      run_pass(0, 1'b0);

      // Random histograms: small counts, sparse, and full-range values.
      for (int t = 0; t < 6; t++) begin
         for (int b = 0; b < 256; b++) begin
            case (t % 3)
               0:       hist[b] = 16'($urandom_range(0, 100));
               1:       hist[b] = ($urandom_range(0, 15) == 0) ? 16'($urandom_range(1, 3000)) : 16'd0;
               default: hist[b] = 16'($urandom);
            endcase
         end
         run_pass(0, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
